// File: rtl/vec_mem_streamer_if.sv
// vec_mem_streamer_if
//   Bundles the request, memory and byte-stream signals of vec_mem_streamer.
//   master : the streamer side (drives mem_addr and the output stream).
//   slave  : the environment side (drives start/base_addr/count, mem_rd, out_ready).
//   Signals:
//     start, base_addr[I], count[16]   transfer request
//     mem_addr[I], mem_rd[R][N]        vector memory port (read data one cycle after address)
//     out_data[N], out_lane[3],
//     out_valid, out_ready, out_last   lane byte stream with valid/ready handshake
//     busy, done                       status
interface vec_mem_streamer_if #(
    parameter int I = 32,
    parameter int N = 8,
    parameter int R = 6
);
    logic                  start;
    logic [I-1:0]          base_addr;
    logic [15:0]           count;
    logic [I-1:0]          mem_addr;
    logic [R-1:0][N-1:0]   mem_rd;
    logic [N-1:0]          out_data;
    logic [2:0]            out_lane;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_last;
    logic                  busy;
    logic                  done;

    modport master (
        input  start, base_addr, count, mem_rd, out_ready,
        output mem_addr, out_data, out_lane, out_valid, out_last, busy, done
    );

    modport slave (
        output start, base_addr, count, mem_rd, out_ready,
        input  mem_addr, out_data, out_lane, out_valid, out_last, busy, done
    );
endinterface

// File: rtl/vec_mem_streamer.sv
// vec_mem_streamer
//   Reads `count` consecutive vector words starting at `base_addr` from a
//   vector memory with one-cycle read latency and streams each word out as
//   R lane bytes (lane 0 first) over a valid/ready handshake.
//   Ports:
//     clk    rising-edge clock
//     reset  synchronous, active-high reset
//     bus    vec_mem_streamer_if.master (request, memory port, byte stream, status)
module vec_mem_streamer #(
    parameter int I = 32,
    parameter int N = 8,
    parameter int R = 6
) (
    input  logic                   clk,
    input  logic                   reset,
    vec_mem_streamer_if.master     bus
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] REQ     = 3'd1;
    localparam logic [2:0] CAPTURE = 3'd2;
    localparam logic [2:0] SEND    = 3'd3;
    localparam logic [2:0] DONE    = 3'd4;

    localparam logic [2:0] LAST_LANE = 3'(R - 1);

    logic [2:0]          state_q,     state_d;
    logic [I-1:0]        cur_addr_q,  cur_addr_d;
    logic [15:0]         remaining_q, remaining_d;
    logic [2:0]          lane_q,      lane_d;
    logic [R-1:0][N-1:0] buf_q,       buf_d;

    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        remaining_d = remaining_q;
        lane_d      = lane_q;
        buf_d       = buf_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.count != 16'd0) begin
                        cur_addr_d  = bus.base_addr;
                        remaining_d = bus.count;
                        state_d     = REQ;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            REQ: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                // Address was presented during REQ, so mem_rd is valid now.
                buf_d   = bus.mem_rd;
                lane_d  = 3'd0;
                state_d = SEND;
            end
            SEND: begin
                if (bus.out_ready) begin
                    if (lane_q == LAST_LANE) begin
                        if (remaining_q == 16'd1) begin
                            state_d = DONE;
                        end else begin
                            // Natural overflow gives the modulo-2^I wrap.
                            cur_addr_d  = cur_addr_q + 1'b1;
                            remaining_d = remaining_q - 16'd1;
                            state_d     = REQ;
                        end
                    end else begin
                        lane_d = lane_q + 3'd1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cur_addr_q  <= '0;
            remaining_q <= '0;
            lane_q      <= '0;
            buf_q       <= '0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            remaining_q <= remaining_d;
            lane_q      <= lane_d;
            buf_q       <= buf_d;
        end
    end

    // Outputs depend only on registered state, so they cannot change while
    // out_ready is low in SEND.
    assign bus.mem_addr  = cur_addr_q;
    assign bus.out_valid = (state_q == SEND);
    assign bus.out_data  = buf_q[lane_q];
    assign bus.out_lane  = lane_q;
    assign bus.out_last  = (state_q == SEND) && (lane_q == LAST_LANE) &&
                           (remaining_q == 16'd1);
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = (state_q == DONE);

endmodule

// File: tb/tb_vec_mem_streamer.sv
// tb_vec_mem_streamer
//   Scoreboard bench for vec_mem_streamer: the stimulus process pushes the
//   expected lane bytes when it starts a transfer, a monitor pops and compares
//   every accepted byte and checks stability during stalls.
module tb_vec_mem_streamer;

    localparam int I = 32;
    localparam int N = 8;
    localparam int R = 6;

    typedef struct packed {
        logic [7:0] d;
        logic [2:0] lane;
        logic       last;
    } exp_t;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;
    exp_t sb[$];

    vec_mem_streamer_if #(.I(I), .N(N), .R(R)) bus ();

    vec_mem_streamer #(.I(I), .N(N), .R(R)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents: address 4 holds {6,5,4,3,2,1}; elsewhere lane l of
    // address a holds ((a[3:0] << 4) | l) ^ 8'h80.
    function automatic logic [7:0] mem_byte(input logic [31:0] a, input int l);
        logic [7:0] b;
        if (a == 32'd4) b = 8'(l + 1);
        else            b = {a[3:0], 4'(l)} ^ 8'h80;
        return b;
    endfunction

    function automatic logic [R-1:0][N-1:0] mem_word(input logic [31:0] a);
        logic [R-1:0][N-1:0] w;
        for (int l = 0; l < R; l++) w[l] = mem_byte(a, l);
        return w;
    endfunction

    always_ff @(posedge clk) bus.mem_rd <= mem_word(bus.mem_addr);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    task automatic push_words(input logic [31:0] base, input int cnt);
        exp_t e;
        logic [31:0] a;
        for (int w = 0; w < cnt; w++) begin
            a = base + 32'(w);
            for (int l = 0; l < R; l++) begin
                e.d    = mem_byte(a, l);
                e.lane = 3'(l);
                e.last = (w == cnt - 1) && (l == R - 1);
                sb.push_back(e);
            end
        end
    endtask

    // Sets up a request in the current cycle (cycle 0).
    task automatic issue(input logic [31:0] base, input logic [15:0] cnt);
        @(posedge clk); #1;
        bus.start     = 1'b1;
        bus.base_addr = base;
        bus.count     = cnt;
    endtask

    // Runs cycles 1.. until done, with optional ready toggling, a stray start
    // pulse, a mem_addr probe and latency checks (-1 disables an option).
    task automatic run(input int maxc, input bit toggle, input int pulse_at,
                       input int addr_cyc, input logic [31:0] addr_exp,
                       input int done_exp, input int first_exp);
        int first_v;
        int done_c;
        first_v = -1;
        done_c  = -1;
        for (int c = 1; c <= maxc; c++) begin
            @(posedge clk); #1;
            bus.start = (c == pulse_at);
            if (c == pulse_at) begin
                bus.base_addr = 32'd99;
                bus.count     = 16'd5;
            end
            if (toggle) bus.out_ready = ~bus.out_ready;
            if (bus.out_valid && first_v < 0) first_v = c;
            if (c == addr_cyc) chk("mem_addr_probe", bus.mem_addr, addr_exp);
            if (bus.done) begin
                done_c = c;
                break;
            end
        end
        chk("done_seen", 32'(done_c >= 0), 32'd1);
        if (done_exp >= 0)  chk("done_cycle", 32'(done_c), 32'(done_exp));
        if (first_exp >= 0) chk("first_valid_cycle", 32'(first_v), 32'(first_exp));
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("done_one_cycle", 32'(bus.done), 32'd0);
        chk("busy_after_done", 32'(bus.busy), 32'd0);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    endtask

    // Monitor: compares accepted bytes against the scoreboard and checks that
    // a stalled byte is presented unchanged on the next cycle.
    initial begin
        logic        held_v;
        logic [12:0] held;
        exp_t        e;
        held_v = 1'b0;
        held   = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                held_v = 1'b0;
            end else begin
                if (held_v)
                    chk("stall_hold", {bus.out_valid, bus.out_last, bus.out_lane, bus.out_data}, held);
                if (bus.out_valid && bus.out_ready) begin
                    if (sb.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_byte: got lane %0d data %0h, required no output",
                                 bus.out_lane, bus.out_data);
                    end else begin
                        e = sb.pop_front();
                        chk("byte_data", bus.out_data, e.d);
                        chk("byte_lane", bus.out_lane, e.lane);
                        chk("byte_last", bus.out_last, e.last);
                    end
                end
                held_v = bus.out_valid && !bus.out_ready;
                held   = {bus.out_valid, bus.out_last, bus.out_lane, bus.out_data};
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        vectors       = 0;
        miscompares   = 0;
        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.base_addr = '0;
        bus.count     = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'd0);
        reset = 1'b0;

        // Single word at address 4, hand-computed bytes 1..6.
        issue(32'd4, 16'd1);
        for (int l = 0; l < R; l++) begin
            e.d = 8'(l + 1); e.lane = 3'(l); e.last = (l == R - 1);
            sb.push_back(e);
        end
        run(50, 1'b0, -1, 1, 32'd4, 9, 3);

        // count = 0: no access, done next cycle, mem_addr keeps 4.
        issue(32'd77, 16'd0);
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("cnt0_done", 32'(bus.done), 32'd1);
        chk("cnt0_busy", 32'(bus.busy), 32'd1);
        chk("cnt0_out_valid", 32'(bus.out_valid), 32'd0);
        chk("cnt0_mem_addr", bus.mem_addr, 32'd4);
        @(posedge clk); #1;
        chk("cnt0_done_low", 32'(bus.done), 32'd0);
        chk("cnt0_mem_addr_after", bus.mem_addr, 32'd4);

        // Three words with out_ready toggling every cycle.
        issue(32'd10, 16'd3);
        push_words(32'd10, 3);
        run(200, 1'b1, -1, -1, '0, -1, 3);

        // Address wrap: second word comes from address 0 (REQ at cycle 9).
        issue(32'hFFFF_FFFF, 16'd2);
        push_words(32'hFFFF_FFFF, 2);
        run(50, 1'b0, -1, 9, 32'd0, 17, 3);

        // Stray start while busy is ignored.
        issue(32'd40, 16'd2);
        push_words(32'd40, 2);
        run(50, 1'b0, 4, 9, 32'd41, 17, 3);
        repeat (3) @(posedge clk);
        #1;
        chk("ignored_start_idle", 32'(bus.busy), 32'd0);

        // Reset while sending lane 2 of the first of three words.
        issue(32'd20, 16'd3);
        push_words(32'd20, 3);
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk); #1;
            bus.start = 1'b0;
        end
        chk("pre_reset_lane", 32'(bus.out_lane), 32'd2);
        reset = 1'b1;
        sb.delete();
        @(posedge clk); #1;
        chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        chk("mid_rst_out_last", 32'(bus.out_last), 32'd0);
        chk("mid_rst_mem_addr", bus.mem_addr, 32'd0);
        chk("mid_rst_out_data", 32'(bus.out_data), 32'd0);
        chk("mid_rst_out_lane", 32'(bus.out_lane), 32'd0);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_quiet", 32'(bus.out_valid), 32'd0);

        // Clean transfer after reset.
        issue(32'd4, 16'd1);
        push_words(32'd4, 1);
        run(50, 1'b0, -1, 1, 32'd4, 9, 3);

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/vec_mem_streamer.md
VEC_MEM_STREAMER -- requirements
Module: vec_mem_streamer

Interface
REQ-001 Parameter I SHALL default to 32 and set the address width.
REQ-002 Parameter N SHALL default to 8 and set the lane width.
REQ-003 Parameter R SHALL default to 6 and set the lanes per vector word.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-006 start  input  1  SHALL request a transfer; it is sampled only in IDLE.
REQ-007 base_addr  input  I  SHALL give the vector-word address of the first word.
REQ-008 count  input  16  SHALL give the number of vector words to transfer.
REQ-009 mem_addr  output  I  SHALL be the address driven to the vector data memory.
REQ-010 mem_rd  input  R x N (packed [R-1:0][N-1:0])  SHALL carry read data, valid one cycle after mem_addr is presented.
REQ-011 out_data  output  N  SHALL carry the current lane byte.
REQ-012 out_lane  output  3  SHALL carry the index (0..R-1) of the current lane.
REQ-013 out_valid  output  1  SHALL mark out_data as valid.
REQ-014 out_ready  input  1  SHALL be the downstream accept; a byte transfers when out_valid and out_ready are both high.
REQ-015 out_last  output  1  SHALL be high with lane R-1 of the final word.
REQ-016 busy  output  1  SHALL be high in every state except IDLE.
REQ-017 done  output  1  SHALL be a one-cycle completion pulse.

Function
REQ-018 The FSM SHALL have exactly these states: IDLE, REQ, CAPTURE, SEND, DONE.
REQ-019 In IDLE with start=1 and count!=0, the block SHALL latch cur_addr=base_addr and remaining=count, then go to REQ.
REQ-020 In IDLE with start=1 and count=0, the block SHALL go to DONE without a memory access.
REQ-021 mem_addr SHALL equal cur_addr in every state.
REQ-022 REQ SHALL last one cycle and then go to CAPTURE.
REQ-023 In CAPTURE, the block SHALL copy mem_rd into an R-lane buffer, set lane=0, and go to SEND.
REQ-024 In SEND, out_valid SHALL be 1, out_data SHALL be buffer[lane], and out_lane SHALL be lane.
REQ-025 On each SEND transfer with lane<R-1, lane SHALL increment.
REQ-026 While out_valid=1 and out_ready=0, out_data, out_lane and out_last SHALL be held stable.
REQ-027 On the transfer of lane R-1 with remaining=1, the block SHALL go to DONE.
REQ-028 On the transfer of lane R-1 with remaining>1, the block SHALL set cur_addr+=1 and remaining-=1, then go to REQ.
REQ-029 cur_addr SHALL wrap modulo 2^I.
REQ-030 DONE SHALL assert done for one cycle and then go to IDLE.
REQ-031 start SHALL be ignored in every state except IDLE.
REQ-032 Latency: with start at cycle 0, the first out_valid SHALL occur at cycle 3.
REQ-033 Throughput: with out_ready held at 1, each word SHALL take R+2 cycles.
REQ-034 out_valid SHALL be 0 in every state except SEND.

Reset
REQ-035 On reset, the next state SHALL be IDLE, including when reset arrives mid-transfer.
REQ-036 On reset, out_valid, out_last, busy and done SHALL be 0.
REQ-037 On reset, mem_addr, out_data and out_lane SHALL be 0, and lane and remaining SHALL be cleared.
REQ-038 A partially sent word SHALL be discarded on reset; no further bytes SHALL be emitted.

Verification
REQ-039 Single word: base_addr=4, count=1, mem[4]={6,5,4,3,2,1} (lane5..0), out_ready=1 -> mem_addr=4; bytes 1,2,3,4,5,6 on lanes 0..5 at cycles 3..8; out_last only on lane 5; done at cycle 9; busy 0 at cycle 10.
REQ-040 Multi-word with backpressure: count=3, base_addr=10, out_ready toggling 1/0 -> 18 bytes in lane order from addresses 10, 11, 12; data held stable on every stall; exactly one out_last.
REQ-041 count=0: start -> no out_valid; done one cycle after start; mem_addr unchanged.
REQ-042 Wrap-around: base_addr=32'hFFFFFFFF, count=2 -> second word read from address 0.
REQ-043 Reset during SEND lane 2 of word 1 of 3 -> out_valid=0 after the reset edge; IDLE; a new start runs a clean transfer from lane 0.
REQ-044 start pulsed while busy -> ignored; the in-flight transfer finishes with unchanged count and addresses.
